// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - multicycle one/two-word instruction fetch unit with PC redirect
module fetch_unit #(
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          ADDR_W   = 13,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_word,
  output logic              inst_long,
  output logic [ADDR_W-1:0] inst_target,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned K = ADDR_W - DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH1,
    S_FETCH2,
    S_HOLD
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_inst_word;
  logic                r_inst_long;
  logic [ADDR_W-1:0]   r_inst_target;
  logic [ADDR_W-1:0]   r_inst_pc;
  logic                w_ack1;
  logic                w_ack2;

  // A redirect swallows any ack arriving in the same cycle.
  assign w_ack1 = (r_state == S_FETCH1) && mem_ack && !redirect_en;
  assign w_ack2 = (r_state == S_FETCH2) && mem_ack && !redirect_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_en) begin
      w_state_nxt = S_FETCH1;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_FETCH1;
        S_FETCH1: if (mem_ack) w_state_nxt = mem_rdata[DATA_W-1] ? S_HOLD : S_FETCH2;
        S_FETCH2: if (mem_ack) w_state_nxt = S_HOLD;
        S_HOLD:   if (inst_ready) w_state_nxt = S_FETCH1;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inst_word   <= '0;
      r_inst_long   <= 1'b0;
      r_inst_target <= '0;
      r_inst_pc     <= '0;
    end else begin
      if (redirect_en) begin
        r_pc <= redirect_pc;
      end else if (w_ack1 || w_ack2) begin
        r_pc <= r_pc + 1'b1;
      end
      if (w_ack1) begin
        r_inst_word <= mem_rdata;
        r_inst_pc   <= r_pc;
        r_inst_long <= !mem_rdata[DATA_W-1];
        if (mem_rdata[DATA_W-1]) begin
          r_inst_target <= '0;
        end
      end
      // Second word supplies the high bits; first-word low K bits fill the bottom.
      if (w_ack2) begin
        r_inst_target <= {mem_rdata, r_inst_word[K-1:0]};
      end
    end
  end

  assign mem_req     = (r_state == S_FETCH1) || (r_state == S_FETCH2);
  assign mem_addr    = r_pc;
  assign inst_valid  = (r_state == S_HOLD);
  assign inst_word   = r_inst_word;
  assign inst_long   = r_inst_long;
  assign inst_target = r_inst_target;
  assign inst_pc     = r_inst_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [12:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [7:0]  inst_word;
  logic        inst_long;
  logic [12:0] inst_target;
  logic [12:0] inst_pc;
  logic        redirect_en = 1'b0;
  logic [12:0] redirect_pc = 13'h0;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:8191];
  bit mem_auto = 1'b1;
  int mem_max_lat = 0;
  int wait_cnt = 0;
  int cur_lat = 0;

  always #5 clk = ~clk;

  fetch_unit #(.DATA_W(8), .ADDR_W(13), .RESET_PC(13'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word),
    .inst_long(inst_long), .inst_target(inst_target), .inst_pc(inst_pc),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc)
  );

  // Advance to the next falling edge and play the memory side for the coming cycle.
  task automatic tick();
    @(negedge clk);
    redirect_en = 1'b0;
    if (mem_auto && mem_req) begin
      if (wait_cnt >= cur_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        wait_cnt  = 0;
        cur_lat   = $urandom_range(mem_max_lat, 0);
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  endtask

  task automatic run_until_valid(input int budget);
    int n;
    n = 0;
    while (!inst_valid && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (!inst_valid) begin
      fails++;
      $display("FAIL wait_valid: inst_valid=%0b after %0d cycles, required 1", inst_valid, n);
    end
  endtask

  function automatic void model(input logic [12:0] pc, output logic [7:0] w,
                                output logic l, output logic [12:0] t);
    logic [12:0] pc2;
    pc2 = pc + 13'd1;
    w = mem[pc];
    l = !w[7];
    t = l ? {mem[pc2], w[4:0]} : 13'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    mem_auto = 1'b1; mem_max_lat = 0; cur_lat = 0; wait_cnt = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({mem_req, inst_valid, inst_long} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl: req/valid/long=%b required 000", {mem_req, inst_valid, inst_long});
    end
    tests++;
    if ({inst_word, inst_target, inst_pc} !== 34'h0) begin
      fails++;
      $display("FAIL reset_data: word=%h target=%h pc=%h required 0", inst_word, inst_target, inst_pc);
    end
    rst = 1'b0;
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL dead_cycle: mem_req=%b required 0", mem_req);
    end
    tick();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h000) begin
      fails++;
      $display("FAIL first_fetch: req=%b addr=%h required 1/000", mem_req, mem_addr);
    end
    tick();
    tests++;
    if (inst_valid !== 1'b1 || inst_word !== 8'hA3 || inst_long !== 1'b0 || inst_pc !== 13'h0) begin
      fails++;
      $display("FAIL short_inst: valid=%b word=%h long=%b pc=%h required 1/a3/0/000",
               inst_valid, inst_word, inst_long, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tests++;
    if (inst_valid !== 1'b0 || mem_addr !== 13'h001) begin
      fails++;
      $display("FAIL next_addr_short: valid=%b addr=%h required 0/001", inst_valid, mem_addr);
    end
  endtask

  task automatic test_long();
    run_until_valid(20);
    tests++;
    if (inst_long !== 1'b1 || inst_target !== 13'hFE5 || inst_pc !== 13'h001 || inst_word !== 8'h25) begin
      fails++;
      $display("FAIL long_inst: long=%b target=%h pc=%h word=%h required 1/fe5/001/25",
               inst_long, inst_target, inst_pc, inst_word);
    end
    mem_auto = 1'b0;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h003) begin
      fails++;
      $display("FAIL next_addr_long: req=%b addr=%h required 1/003", mem_req, mem_addr);
    end
  endtask

  task automatic test_stall();
    mem_ack = 1'b1; mem_rdata = mem[3];
    tick();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 13'h004 || inst_valid !== 1'b0) begin
        fails++;
        $display("FAIL fetch2_wait%0d: req=%b addr=%h valid=%b required 1/004/0",
                 i, mem_req, mem_addr, inst_valid);
      end
      tick();
    end
    mem_ack = 1'b1; mem_rdata = mem[4];
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (inst_valid !== 1'b1 || mem_req !== 1'b0 || inst_word !== 8'h10 || inst_long !== 1'b1 ||
          inst_target !== 13'h670 || inst_pc !== 13'h003) begin
        fails++;
        $display("FAIL hold_stable%0d: valid=%b req=%b word=%h long=%b target=%h pc=%h required 1/0/10/1/670/003",
                 i, inst_valid, mem_req, inst_word, inst_long, inst_target, inst_pc);
      end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tests++;
    if (inst_valid !== 1'b0 || mem_addr !== 13'h005) begin
      fails++;
      $display("FAIL stall_consume: valid=%b addr=%h required 0/005", inst_valid, mem_addr);
    end
    tick();
    tests++;
    if (inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_delivery: valid=%b required 0", inst_valid);
    end
  endtask

  task automatic test_redirect_ack();
    mem_ack = 1'b1; mem_rdata = mem[5];
    tick();
    tests++;
    if (mem_addr !== 13'h006 || mem_req !== 1'b1) begin
      fails++;
      $display("FAIL redir_pre: addr=%h req=%b required 006/1", mem_addr, mem_req);
    end
    mem_ack = 1'b1; mem_rdata = mem[6];
    redirect_en = 1'b1; redirect_pc = 13'h100;
    tick();
    tests++;
    if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 13'h100) begin
      fails++;
      $display("FAIL redir_ack: valid=%b req=%b addr=%h required 0/1/100", inst_valid, mem_req, mem_addr);
    end
    mem_auto = 1'b1; mem_max_lat = 0; cur_lat = 0;
    run_until_valid(20);
    tests++;
    if (inst_pc !== 13'h100 || inst_word !== 8'h80 || inst_long !== 1'b0) begin
      fails++;
      $display("FAIL redir_first: pc=%h word=%h long=%b required 100/80/0", inst_pc, inst_word, inst_long);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_wrap();
    redirect_en = 1'b1; redirect_pc = 13'h1FFF;
    tick();
    tests++;
    if (mem_addr !== 13'h1FFF || mem_req !== 1'b1) begin
      fails++;
      $display("FAIL wrap_redir: addr=%h req=%b required 1fff/1", mem_addr, mem_req);
    end
    run_until_valid(20);
    tests++;
    if (inst_long !== 1'b1 || inst_target !== 13'h245 || inst_pc !== 13'h1FFF || inst_word !== 8'h05) begin
      fails++;
      $display("FAIL wrap_inst: long=%b target=%h pc=%h word=%h required 1/245/1fff/05",
               inst_long, inst_target, inst_pc, inst_word);
    end
    mem_auto = 1'b0;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tests++;
    if (mem_addr !== 13'h0001) begin
      fails++;
      $display("FAIL wrap_next: addr=%h required 0001", mem_addr);
    end
  endtask

  task automatic test_reset_mid();
    #2 rst = 1'b1;
    #1;
    tests++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: req=%b valid=%b required 0/0", mem_req, inst_valid);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'h7F;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: req=%b required 0", mem_req);
    end
    tick();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h000 || inst_word !== 8'h00 || inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL late_ack: req=%b addr=%h word=%h valid=%b required 1/000/00/0",
               mem_req, mem_addr, inst_word, inst_valid);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp_pc;
    logic [12:0] ea;
    logic [12:0] rpc;
    logic [7:0]  ew;
    logic        el;
    logic [12:0] et;
    logic [31:0] r;
    int words_got;
    int delivered;
    for (int i = 0; i < 8192; i++) begin
      r = $urandom;
      mem[i] = r[7:0];
    end
    mem_auto = 1'b1; mem_max_lat = 3;
    inst_ready = 1'b0;
    r = $urandom;
    redirect_en = 1'b1; redirect_pc = r[12:0];
    exp_pc = r[12:0];
    words_got = 0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      inst_ready = ($urandom_range(2, 0) != 0);
      if ($urandom_range(15, 0) == 0) begin
        r = $urandom;
        rpc = ($urandom_range(3, 0) == 0) ? 13'h1FFF : r[12:0];
        redirect_en = 1'b1;
        redirect_pc = rpc;
      end
      if (inst_valid && inst_ready) begin
        model(exp_pc, ew, el, et);
        tests++;
        if (inst_word !== ew || inst_long !== el || inst_target !== et || inst_pc !== exp_pc) begin
          fails++;
          $display("FAIL rand_inst@%0d: word=%h long=%b target=%h pc=%h required %h/%b/%h/%h",
                   c, inst_word, inst_long, inst_target, inst_pc, ew, el, et, exp_pc);
        end
        exp_pc = exp_pc + (el ? 13'd2 : 13'd1);
        words_got = 0;
        delivered++;
      end else if (mem_req && mem_ack && !redirect_en) begin
        ea = exp_pc + 13'(words_got);
        tests++;
        if (mem_addr !== ea) begin
          fails++;
          $display("FAIL rand_addr@%0d: addr=%h required %h", c, mem_addr, ea);
        end
        words_got++;
      end
      if (redirect_en) begin
        exp_pc = redirect_pc;
        words_got = 0;
      end
    end
    tests++;
    if (delivered < 100) begin
      fails++;
      $display("FAIL rand_progress: delivered=%0d required >=100", delivered);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h80;
    mem[0] = 8'hA3;
    mem[1] = 8'h25;
    mem[2] = 8'h7F;
    mem[3] = 8'h10;
    mem[4] = 8'h33;
    mem[5] = 8'h01;
    mem[6] = 8'h44;
    mem[13'h100] = 8'h80;
    mem[13'h1FFF] = 8'h05;
    test_reset();
    test_long();
    test_stall();
    test_redirect_ack();
    mem[0] = 8'h12;
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised multicycle instruction fetch unit for the accumulator/register-file core. It owns the PC and fetches one- or two-word instructions from word-wide memory over a req/ack handshake. It assembles the long-form target address, as TR does today, and holds the fetched instruction for the execute controller under a valid/ready handshake. It also accepts PC redirects from jump resolution.

Parameters:
DATA_W, 8, memory word and instruction word width
ADDR_W, 13, PC / memory address width; legal range DATA_W < ADDR_W <= 2*DATA_W-1
RESET_PC, 0, PC value loaded on reset
K (localparam), ADDR_W-DATA_W, number of first-word low bits used as target high-order bits

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  read address, stable while mem_req=1
mem_ack  in  1  read complete; mem_rdata valid this cycle
mem_rdata  in  DATA_W  read data
inst_valid  out  1  instruction held and presented
inst_ready  in  1  consumer accepts instruction
inst_word  out  DATA_W  first instruction word (opcode + fields)
inst_long  out  1  instruction was two-word
inst_target  out  ADDR_W  {second word, first word[K-1:0]}; 0 for short instructions
inst_pc  out  ADDR_W  address of the first word
redirect_en  in  1  load redirect_pc and restart fetch
redirect_pc  in  ADDR_W  new PC

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, mem_req=0, inst_valid=0, inst_word=0, inst_long=0, inst_target=0, inst_pc=0.
- States are IDLE, FETCH1, FETCH2 and HOLD. mem_req=1 exactly in FETCH1/FETCH2. inst_valid=1 exactly in HOLD.
- IDLE: go to FETCH1 next cycle unconditionally. This gives one dead cycle after reset deassertion.
- FETCH1: mem_addr=pc. On mem_ack:
  - inst_word<=mem_rdata, inst_pc<=pc, pc<=pc+1.
  - If mem_rdata[DATA_W-1]==0, the instruction is long: inst_long<=1, go to FETCH2.
  - Otherwise: inst_long<=0, inst_target<=0, go to HOLD.
- FETCH2: mem_addr=pc. On mem_ack: inst_target<={mem_rdata, inst_word[K-1:0]}, pc<=pc+1, go to HOLD.
- Without mem_ack, FETCH1/FETCH2 hold with mem_addr unchanged. Wait is unbounded; there is no timeout.
- mem_ack may arrive in the same cycle as mem_req is first raised (zero-wait memory).
- Latency with zero-wait memory: short instruction takes 1 cycle from FETCH1 entry to inst_valid; long takes 2.
- HOLD: outputs stable while inst_ready=0. On inst_ready=1 the instruction is consumed and the unit goes to FETCH1 next cycle. Throughput is therefore at most one short instruction per 2 cycles.
- PC arithmetic is modulo 2^ADDR_W. pc=all-ones increments to 0, and a long instruction may straddle the wrap.
- Redirect has priority over everything except reset:
  - Effect: pc<=redirect_pc, state<=FETCH1, inst_valid=0 from the next cycle.
  - Redirect in FETCH1/FETCH2 with mem_ack in the same cycle: the ack is consumed and its data discarded. inst_* registers are left unchanged.
  - Redirect in FETCH2 without ack: the request is abandoned. mem_req drops for 0 cycles, and mem_addr changes to redirect_pc next cycle.
  - Redirect in HOLD with inst_ready=1: the consumer did take the instruction; the redirect still applies.
  - Redirect in IDLE: takes effect; next state is FETCH1 at redirect_pc.
- Memory contract on abandonment: the memory must accept mem_addr changing only after an ack or a redirect.
- Reset asserted mid-request: mem_req drops immediately (async). Any later ack is ignored because the state is IDLE.
- inst_target is meaningful only when inst_long=1.

Test Plan:
- Reset sequence, then mem[0]=0xA3 with zero-wait memory -> mem_req=0 for 1 cycle after reset release; HOLD gives inst_word=0xA3, inst_long=0, inst_pc=0x000; next fetch addr=0x001.
- mem[1]=0x25, mem[2]=0x7F -> inst_long=1, inst_target=0xFE5, inst_pc=0x001; next fetch addr=0x003.
- inst_ready held 0 for 5 cycles in HOLD, mem_ack delayed 3 cycles in FETCH2 -> all inst_* stable, mem_addr stable, exactly one instruction delivered on ready.
- redirect_en with redirect_pc=0x100 in FETCH2 in the same cycle as mem_ack -> ack data discarded, inst_valid never rises for that instruction, next mem_addr=0x100.
- pc=0x1FFF with a long first word 0x05 and mem[0x0000]=0x12 -> inst_target=0x245, inst_pc=0x1FFF, next fetch addr=0x0001.
- rst pulsed while in FETCH1 awaiting ack, with a late ack afterwards -> mem_req=0 immediately, ack ignored, fetch restarts at RESET_PC after the IDLE cycle.
